sccb_config_seq: RTL and testbench

- Upstream feeder for the SCCB sender. Walks a fixed OV7670 register-setting table and presents one register/value pair at a time, using a send/taken handshake.
- Inserts programmed wait intervals, such as after the COM7 soft reset. Stops on an end marker and flags completion to the capture/VGA path.
- A resend request replays the whole table from entry 0.

---
 rtl/ov7670_cfg_pkg.sv | 29 ++
 rtl/ov7670_reg_rom.sv | 21 ++
 rtl/sccb_config_seq.sv | 118 +++++++++++
 tb/tb_sccb_config_seq.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/ov7670_cfg_pkg.sv
// OV7670 configuration table, sequencer state encoding and table markers.
package ov7670_cfg_pkg;

  typedef enum logic [2:0] {PWRUP, FETCH, DECODE, SEND, DELAY, DONE} cfg_state_t;

  localparam int unsigned CNT_W     = 24;
  localparam logic [15:0] CFG_END   = 16'hFFFF;
  localparam logic [15:0] CFG_DELAY = 16'hFFF0;

  localparam int unsigned CFG_LEN   = 12;
  localparam int unsigned TAB_IDX_W = $clog2(CFG_LEN);

  // {reg, val} pairs; COM7 soft reset needs a settle interval before anything else.
  localparam logic [0:CFG_LEN-1][15:0] CFG_TABLE = {
    16'h1280,   // COM7: soft reset
    CFG_DELAY,
    16'h1204,   // COM7: RGB output
    16'h1180,   // CLKRC
    16'h0C00,   // COM3
    16'h3E00,   // COM14
    16'h8C00,   // RGB444 off
    16'h0400,   // COM1
    16'h40D0,   // COM15: RGB565, full range
    16'h3A04,   // TSLB
    16'h1438,   // COM9: AGC ceiling
    CFG_END
  };

endpackage

// File: rtl/ov7670_reg_rom.sv
// Registered-output lookup of the configuration table; out-of-range reads return the end marker.
module ov7670_reg_rom
  import ov7670_cfg_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  output logic [15:0]       data
);

  logic [15:0] r_data;

  always_ff @(posedge clk) begin
    if (32'(addr) < CFG_LEN) r_data <= CFG_TABLE[addr[TAB_IDX_W-1:0]];
    else                     r_data <= CFG_END;
  end

  assign data = r_data;

endmodule

// File: rtl/sccb_config_seq.sv
// Walks the OV7670 register table and hands one {reg, val} pair at a time to the SCCB sender.
module sccb_config_seq
  import ov7670_cfg_pkg::*;
#(
  parameter logic [7:0]       CAM_ID       = 8'h42,
  parameter int unsigned      ADDR_W       = 8,
  parameter logic [CNT_W-1:0] PWRUP_CYCLES = 24'd1_000_000,
  parameter logic [CNT_W-1:0] DELAY_CYCLES = 24'd1_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              resend,
  input  logic              taken,
  output logic              send,
  output logic [7:0]        id,
  output logic [7:0]        regi,
  output logic [7:0]        value,
  output logic              config_done,
  output logic [ADDR_W-1:0] entry_idx
);

  localparam logic [ADDR_W-1:0] IDX_LAST = '1;

  cfg_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0] r_entry_idx, w_entry_idx_nxt;
  logic [7:0]        r_regi, w_regi_nxt;
  logic [7:0]        r_value, w_value_nxt;
  logic              r_send, w_send_nxt;
  logic              r_done, w_done_nxt;
  logic [15:0]       w_rom_data;
  logic              w_restart;

  ov7670_reg_rom #(.ADDR_W(ADDR_W)) u_rom (
    .clk  (clk),
    .addr (r_entry_idx),
    .data (w_rom_data)
  );

  assign w_restart = resend && (r_state != PWRUP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= PWRUP;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      PWRUP:  if (r_cnt == '0) w_state_nxt = FETCH;
      FETCH:  w_state_nxt = DECODE;
      DECODE: begin
        if      (w_rom_data == CFG_END)   w_state_nxt = DONE;
        else if (w_rom_data == CFG_DELAY) w_state_nxt = DELAY;
        else                              w_state_nxt = SEND;
      end
      SEND:   if (taken) w_state_nxt = (r_entry_idx == IDX_LAST) ? DONE : FETCH;
      DELAY:  if (r_cnt == '0) w_state_nxt = (r_entry_idx == IDX_LAST) ? DONE : FETCH;
      DONE:   w_state_nxt = DONE;
      default: w_state_nxt = PWRUP;
    endcase
    // Replay overrides everything, including a taken in the same cycle.
    if (w_restart) w_state_nxt = FETCH;
  end

  always_comb begin
    w_cnt_nxt       = r_cnt;
    w_entry_idx_nxt = r_entry_idx;
    w_regi_nxt      = r_regi;
    w_value_nxt     = r_value;
    case (r_state)
      PWRUP:  if (r_cnt != '0) w_cnt_nxt = r_cnt - CNT_W'(1);
      DECODE: begin
        if (w_rom_data == CFG_DELAY) begin
          w_cnt_nxt = DELAY_CYCLES - CNT_W'(1);
        end else if (w_rom_data != CFG_END) begin
          w_regi_nxt  = w_rom_data[15:8];
          w_value_nxt = w_rom_data[7:0];
        end
      end
      SEND:   if (taken && (r_entry_idx != IDX_LAST)) w_entry_idx_nxt = r_entry_idx + ADDR_W'(1);
      DELAY: begin
        if (r_cnt != '0)                      w_cnt_nxt = r_cnt - CNT_W'(1);
        else if (r_entry_idx != IDX_LAST)     w_entry_idx_nxt = r_entry_idx + ADDR_W'(1);
      end
      default: ;
    endcase
    if (w_restart) w_entry_idx_nxt = '0;
    w_send_nxt = (w_state_nxt == SEND);
    w_done_nxt = (w_state_nxt == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= PWRUP_CYCLES - CNT_W'(1);
      r_entry_idx <= '0;
      r_regi      <= '0;
      r_value     <= '0;
      r_send      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_entry_idx <= w_entry_idx_nxt;
      r_regi      <= w_regi_nxt;
      r_value     <= w_value_nxt;
      r_send      <= w_send_nxt;
      r_done      <= w_done_nxt;
    end
  end

  assign send        = r_send;
  assign id          = CAM_ID;
  assign regi        = r_regi;
  assign value       = r_value;
  assign config_done = r_done;
  assign entry_idx   = r_entry_idx;

endmodule

// File: tb/tb_sccb_config_seq.sv
// Directed bench for sccb_config_seq with shortened power-up and delay intervals.
module tb_sccb_config_seq;

  localparam int unsigned ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              resend;
  logic              taken;
  logic              send;
  logic [7:0]        id;
  logic [7:0]        regi;
  logic [7:0]        value;
  logic              config_done;
  logic [ADDR_W-1:0] entry_idx;

  int n_cmp = 0;
  int n_err = 0;

  // Expected table, written out independently of the package.
  logic [15:0] exp_tab [12] = '{
    16'h1280, 16'hFFF0, 16'h1204, 16'h1180, 16'h0C00, 16'h3E00,
    16'h8C00, 16'h0400, 16'h40D0, 16'h3A04, 16'h1438, 16'hFFFF
  };

  sccb_config_seq #(
    .CAM_ID       (8'h42),
    .ADDR_W       (ADDR_W),
    .PWRUP_CYCLES (24'd10),
    .DELAY_CYCLES (24'd20)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .resend      (resend),
    .taken       (taken),
    .send        (send),
    .id          (id),
    .regi        (regi),
    .value       (value),
    .config_done (config_done),
    .entry_idx   (entry_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_send(input string tag);
    int i = 0;
    while (!send && i < 100) begin
      step(1);
      i++;
    end
    chk({tag, "_wait_send"}, 32'(send), 1);
  endtask

  // Sender model: accept the pair five cycles after send is seen.
  task automatic take(input string tag);
    step(4);
    taken = 1'b1;
    step(1);
    taken = 1'b0;
    chk({tag, "_send_fall"}, 32'(send), 0);
  endtask

  task automatic powerup_check(input string tag);
    for (int i = 0; i < 11; i++) begin
      step(1);
      chk({tag, "_pwrup_send_low"}, 32'(send), 0);
    end
    step(1);
    chk({tag, "_first_send"}, 32'(send), 1);
    chk({tag, "_first_regi"}, 32'(regi), 32'h12);
    chk({tag, "_first_value"}, 32'(value), 32'h80);
    chk({tag, "_first_id"}, 32'(id), 32'h42);
    chk({tag, "_first_idx"}, 32'(entry_idx), 0);
  endtask

  initial begin
    rst_n  = 1'b0;
    resend = 1'b0;
    taken  = 1'b0;
    step(2);
    chk("rst_send", 32'(send), 0);
    chk("rst_regi", 32'(regi), 0);
    chk("rst_value", 32'(value), 0);
    chk("rst_done", 32'(config_done), 0);
    chk("rst_idx", 32'(entry_idx), 0);
    chk("rst_id", 32'(id), 32'h42);
    rst_n = 1'b1;

    powerup_check("boot");
    step(4);
    chk("hold_send", 32'(send), 1);
    chk("hold_regi", 32'(regi), 32'h12);
    chk("hold_value", 32'(value), 32'h80);

    // Entry 0 accepted; entry 1 is a 20-cycle delay, with a stray taken inside it.
    taken = 1'b1;
    step(1);
    taken = 1'b0;
    chk("e0_send_fall", 32'(send), 0);
    chk("e0_idx_adv", 32'(entry_idx), 1);
    for (int i = 1; i <= 23; i++) begin
      step(1);
      if (i == 5) taken = 1'b1;
      if (i == 6) taken = 1'b0;
      chk("delay_send_low", 32'(send), 0);
      if (i == 10) chk("delay_idx_hold", 32'(entry_idx), 1);
    end
    step(1);
    chk("e2_send", 32'(send), 1);
    chk("e2_regi", 32'(regi), 32'h12);
    chk("e2_value", 32'(value), 32'h04);
    chk("e2_idx", 32'(entry_idx), 2);

    for (int k = 2; k <= 10; k++) begin
      wait_send("walk");
      chk("walk_regi", 32'(regi), 32'(exp_tab[k][15:8]));
      chk("walk_value", 32'(value), 32'(exp_tab[k][7:0]));
      chk("walk_idx", 32'(entry_idx), 32'(k));
      take("walk");
    end

    for (int i = 0; i < 20 && !config_done; i++) step(1);
    chk("done_flag", 32'(config_done), 1);
    chk("done_send", 32'(send), 0);
    chk("done_idx", 32'(entry_idx), 11);
    step(5);
    chk("done_stay_send", 32'(send), 0);
    chk("done_stay_flag", 32'(config_done), 1);

    // Replay from DONE skips the power-up wait.
    resend = 1'b1;
    step(1);
    resend = 1'b0;
    chk("rs_done_fall", 32'(config_done), 0);
    chk("rs_idx", 32'(entry_idx), 0);
    chk("rs_send", 32'(send), 0);
    step(1);
    chk("rs_decode_send", 32'(send), 0);
    step(1);
    chk("rs_send_rise", 32'(send), 1);
    chk("rs_regi", 32'(regi), 32'h12);
    chk("rs_value", 32'(value), 32'h80);

    take("rs_e0");
    for (int k = 2; k <= 4; k++) begin
      wait_send("rs_walk");
      chk("rs_walk_idx", 32'(entry_idx), 32'(k));
      take("rs_walk");
    end
    wait_send("e5");
    chk("e5_idx", 32'(entry_idx), 5);
    chk("e5_regi", 32'(regi), 32'h3E);
    chk("e5_value", 32'(value), 32'h00);

    // resend and taken together: replay wins.
    step(2);
    resend = 1'b1;
    taken  = 1'b1;
    step(1);
    resend = 1'b0;
    taken  = 1'b0;
    chk("rt_idx", 32'(entry_idx), 0);
    chk("rt_send", 32'(send), 0);
    chk("rt_done", 32'(config_done), 0);
    step(2);
    chk("rt_send_rise", 32'(send), 1);
    chk("rt_regi", 32'(regi), 32'h12);
    chk("rt_value", 32'(value), 32'h80);

    // Async reset in the middle of the post-COM7 delay.
    take("mr_e0");
    step(6);
    chk("mr_pre_idx", 32'(entry_idx), 1);
    rst_n = 1'b0;
    #1;
    chk("mr_send", 32'(send), 0);
    chk("mr_regi", 32'(regi), 0);
    chk("mr_value", 32'(value), 0);
    chk("mr_idx", 32'(entry_idx), 0);
    chk("mr_done", 32'(config_done), 0);
    step(2);
    rst_n = 1'b1;
    powerup_check("reboot");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
